// File: rtl/dcache_mon_pkg.sv
// Shared definitions for the data-cache event monitor: event kind bit positions
// and the miss-event record layout.
package dcache_mon_pkg;

    localparam int KIND_WRITE = 0;
    localparam int KIND_MISS  = 1;
    localparam int KIND_WB    = 2;
    localparam int KIND_W     = 3;

    localparam int REC_ADDR_W = 32;
    localparam int REC_CNT_W  = 32;

    typedef logic [KIND_W-1:0] evt_kind_t;

    // Record layout at default widths; the top packs the same field order
    // (addr, kind, cycle) at its own parameterised widths.
    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        evt_kind_t             kind;
        logic [REC_CNT_W-1:0]  cycle;
    } evt_rec_t;

    function automatic evt_kind_t miss_kind(input logic is_write, input logic dirty);
        evt_kind_t k;
        k             = '0;
        k[KIND_WRITE] = is_write;
        k[KIND_MISS]  = 1'b1;
        k[KIND_WB]    = dirty;
        return k;
    endfunction

endpackage

// File: rtl/mon_fifo.sv
// Generic show-ahead FIFO; head data is registered and holds the last popped
// entry once the FIFO runs empty.
module mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop, do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = head_q;

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_i;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Reading through mem_d covers a push into an empty FIFO.
            if (rd_ptr_d != wr_ptr_d) begin
                head_d = mem_d[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dcache_event_monitor.sv
// Data-cache observer: classifies accesses into hit/miss/write-back classes,
// counts them, queues miss records and schedules a one-shot flush request.
module dcache_event_monitor
    import dcache_mon_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int FLUSH_CYCLE = 150
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic              stall_i,
    input  logic              idle_i,
    input  logic              dirty_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  rd_hit_o,
    output logic [CNT_W-1:0]  rd_miss_o,
    output logic [CNT_W-1:0]  wr_hit_o,
    output logic [CNT_W-1:0]  wr_miss_o,
    output logic [CNT_W-1:0]  wb_o,
    output logic              flush_req_o,
    output logic              done_o,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [ADDR_W-1:0] evt_addr_o,
    output logic [2:0]        evt_kind_o,
    output logic [CNT_W-1:0]  evt_cycle_o,
    output logic              evt_overflow_o,
    output logic [CNT_W-1:0]  evt_drop_o
);

    localparam int               REC_W     = ADDR_W + KIND_W + CNT_W;
    localparam logic [CNT_W-1:0] FLUSH_VAL = CNT_W'(FLUSH_CYCLE);

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] rd_hit_q, rd_hit_d;
    logic [CNT_W-1:0] rd_miss_q, rd_miss_d;
    logic [CNT_W-1:0] wr_hit_q, wr_hit_d;
    logic [CNT_W-1:0] wr_miss_q, wr_miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             flag_q, flag_d;
    logic             ovf_q, ovf_d;

    logic             access, is_write, miss, hit, pop;
    logic             fifo_full, fifo_empty;
    logic [REC_W-1:0] push_rec, head_rec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        access    = memread_i | memwrite_i;
        is_write  = memwrite_i;
        // flag marks a miss already recorded for the current stall episode.
        miss      = start_i & stall_i & idle_i & access & ~flag_q;
        hit       = start_i & ~stall_i & access & ~flag_q;
        pop       = ~fifo_empty & evt_ready_i;
        push_rec  = {addr_i, miss_kind(is_write, dirty_i), cycle_q};

        cycle_d   = cycle_q;
        rd_hit_d  = rd_hit_q;
        rd_miss_d = rd_miss_q;
        wr_hit_d  = wr_hit_q;
        wr_miss_d = wr_miss_q;
        wb_d      = wb_q;
        drop_d    = drop_q;
        flag_d    = flag_q;
        ovf_d     = ovf_q;

        if (clear_i) begin
            cycle_d   = '0;
            rd_hit_d  = '0;
            rd_miss_d = '0;
            wr_hit_d  = '0;
            wr_miss_d = '0;
            wb_d      = '0;
            drop_d    = '0;
            flag_d    = 1'b0;
            ovf_d     = 1'b0;
        end else if (start_i) begin
            cycle_d   = sat_inc(cycle_q, 1'b1);
            rd_hit_d  = sat_inc(rd_hit_q, hit & ~is_write);
            wr_hit_d  = sat_inc(wr_hit_q, hit & is_write);
            rd_miss_d = sat_inc(rd_miss_q, miss & ~is_write);
            wr_miss_d = sat_inc(wr_miss_q, miss & is_write);
            wb_d      = sat_inc(wb_q, miss & dirty_i);
            if (miss && fifo_full && !pop) begin
                drop_d = sat_inc(drop_q, 1'b1);
                ovf_d  = 1'b1;
            end
            if (miss) begin
                flag_d = 1'b1;
            end else if (!stall_i) begin
                flag_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q   <= '0;
            rd_hit_q  <= '0;
            rd_miss_q <= '0;
            wr_hit_q  <= '0;
            wr_miss_q <= '0;
            wb_q      <= '0;
            drop_q    <= '0;
            flag_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            rd_hit_q  <= rd_hit_d;
            rd_miss_q <= rd_miss_d;
            wr_hit_q  <= wr_hit_d;
            wr_miss_q <= wr_miss_d;
            wb_q      <= wb_d;
            drop_q    <= drop_d;
            flag_q    <= flag_d;
            ovf_q     <= ovf_d;
        end
    end

    mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (miss),
        .data_i  (push_rec),
        .pop_i   (pop),
        .data_o  (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cycle_cnt_o    = cycle_q;
    assign rd_hit_o       = rd_hit_q;
    assign rd_miss_o      = rd_miss_q;
    assign wr_hit_o       = wr_hit_q;
    assign wr_miss_o      = wr_miss_q;
    assign wb_o           = wb_q;
    assign evt_drop_o     = drop_q;
    assign evt_overflow_o = ovf_q;
    assign flush_req_o    = (cycle_q == FLUSH_VAL);
    assign done_o         = (cycle_q > FLUSH_VAL);
    assign evt_valid_o    = ~fifo_empty;
    assign evt_addr_o     = head_rec[REC_W-1 -: ADDR_W];
    assign evt_kind_o     = head_rec[CNT_W +: KIND_W];
    assign evt_cycle_o    = head_rec[CNT_W-1:0];

endmodule
